branch_unit: RTL and testbench

Parametrised branch resolution and prediction unit for the core pipeline. It resolves conditional branches in EX from the comparator flags and `funct3`, exactly as the existing combinational decision logic does. It adds a direct-mapped table of 2-bit saturating counters that fetch reads for a taken/not-taken prediction. It flags mispredictions with a registered pulse for the redirect/flush logic, and optionally keeps performance counters.

---
 rtl/branch_unit_if.sv | 70 +++++++
 rtl/branch_unit.sv | 136 +++++++++++++
 tb/tb_branch_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_unit_if.sv
// Bundle of fetch-side prediction and EX-side resolve signals shared between
// the pipeline (master) and the branch unit (slave).
// Optional macro: BRANCH_STATS_EN adds the br_count/miss_count statistics.
interface branch_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  // Fetch-side prediction lookup
  logic [XLEN-1:0]  fetch_pc;
  logic             pred_taken;

  // EX-side resolve inputs
  logic             ex_valid;
  logic             ex_branch;
  logic [2:0]       ex_funct3;
  logic             ex_eq;
  logic             ex_ge;
  logic             ex_less;
  logic             ex_ge_u;
  logic             ex_less_u;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_pred_taken;
  logic             flush;

  // Resolve results
  logic             taken;
  logic             mispredict;
  logic             mispredict_taken;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] miss_count;

  modport master (
    output fetch_pc, ex_valid, ex_branch, ex_funct3,
           ex_eq, ex_ge, ex_less, ex_ge_u, ex_less_u,
           ex_pc, ex_pred_taken, flush,
    input  pred_taken, taken, mispredict, mispredict_taken,
           br_count, miss_count
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_branch, ex_funct3,
           ex_eq, ex_ge, ex_less, ex_ge_u, ex_less_u,
           ex_pc, ex_pred_taken, flush,
    output pred_taken, taken, mispredict, mispredict_taken,
           br_count, miss_count
  );
`else
  // Keeps the counter width parameter referenced when statistics are absent
  logic [CNT_W-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;

  modport master (
    output fetch_pc, ex_valid, ex_branch, ex_funct3,
           ex_eq, ex_ge, ex_less, ex_ge_u, ex_less_u,
           ex_pc, ex_pred_taken, flush,
    input  pred_taken, taken, mispredict, mispredict_taken
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_branch, ex_funct3,
           ex_eq, ex_ge, ex_less, ex_ge_u, ex_less_u,
           ex_pc, ex_pred_taken, flush,
    output pred_taken, taken, mispredict, mispredict_taken
  );
`endif

endinterface

// File: rtl/branch_unit.sv
// Branch resolution and 2-bit saturating-counter prediction unit.
// Resolves conditional branches in EX, trains a direct-mapped counter table
// read by fetch, and raises a registered mispredict pulse for redirect logic.
// Optional macro: BRANCH_STATS_EN adds resolved/mispredicted branch counters.
// IDX_BITS is intended to lie in 1..12 and XLEN must exceed IDX_BITS+2.
module branch_unit #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  branch_unit_if.slave bus
);

  localparam int ENTRIES = 1 << IDX_BITS;

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_ST  = 2'b11;

  logic [1:0]          table_q [ENTRIES];
  logic [IDX_BITS-1:0] fetch_idx;
  logic [IDX_BITS-1:0] ex_idx;
  logic                cond_met;
  logic                legal;
  logic                taken;
  logic                res;
  logic                miss;
  logic [1:0]          ex_cnt;
  logic [1:0]          ex_cnt_next;
  logic                mispredict_q;
  logic                mispredict_taken_q;

  // Word-aligned PCs: the low two bits never select an entry
  assign fetch_idx = bus.fetch_pc[IDX_BITS+1:2];
  assign ex_idx    = bus.ex_pc[IDX_BITS+1:2];

  // PC bits outside the index field do not participate in prediction
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.fetch_pc[XLEN-1:IDX_BITS+2], bus.fetch_pc[1:0],
                            bus.ex_pc[XLEN-1:IDX_BITS+2], bus.ex_pc[1:0]};

  // Decode funct3 into the comparator condition and its legality
  always_comb begin
    cond_met = 1'b0;
    legal    = 1'b1;
    case (bus.ex_funct3)
      3'b000:  cond_met = bus.ex_eq;
      3'b001:  cond_met = ~bus.ex_eq;
      3'b100:  cond_met = bus.ex_less;
      3'b101:  cond_met = bus.ex_ge;
      3'b110:  cond_met = bus.ex_less_u;
      3'b111:  cond_met = bus.ex_ge_u;
      default: legal    = 1'b0;
    endcase
  end

  // Outcome is only meaningful for a valid branch; squashed ones still report it
  assign taken = bus.ex_valid & bus.ex_branch & cond_met;
  assign res   = bus.ex_valid & bus.ex_branch & ~bus.flush & legal;
  assign miss  = res & (taken != bus.ex_pred_taken);

  // Prediction is the pre-update table contents; no write-to-read bypass
  assign bus.pred_taken = table_q[fetch_idx][1];
  assign bus.taken      = taken;

  // Saturating increment on taken, decrement on not-taken
  always_comb begin
    ex_cnt      = table_q[ex_idx];
    ex_cnt_next = ex_cnt;
    if (taken) begin
      if (ex_cnt != CNT_ST) begin
        ex_cnt_next = ex_cnt + 2'b01;
      end
    end else begin
      if (ex_cnt != CNT_SNT) begin
        ex_cnt_next = ex_cnt - 2'b01;
      end
    end
  end

  // Counter table: reset clears all training to weak-NT, then trains on resolves
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= CNT_WNT;
      end
    end else if (res) begin
      table_q[ex_idx] <= ex_cnt_next;
    end
  end

  // One-cycle mispredict pulse with the actual direction for the redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_q       <= 1'b0;
      mispredict_taken_q <= 1'b0;
    end else begin
      mispredict_q       <= miss;
      mispredict_taken_q <= miss & taken;
    end
  end

  assign bus.mispredict       = mispredict_q;
  assign bus.mispredict_taken = mispredict_taken_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] miss_count_q;

  // Statistics: misses are counted from the registered pulse, so they lag by one
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      if (res) begin
        br_count_q <= br_count_q + 1'b1;
      end
      if (mispredict_q) begin
        miss_count_q <= miss_count_q + 1'b1;
      end
    end
  end

  assign bus.br_count   = br_count_q;
  assign bus.miss_count = miss_count_q;
`else
  // Keeps the counter width parameter referenced when statistics are absent
  logic [CNT_W-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit (IDX_BITS = 6).
// Statistics checks are compiled in when BRANCH_STATS_EN is defined.
module tb_branch_unit;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  branch_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

  branch_unit #(
    .XLEN(32),
    .IDX_BITS(6),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Drive the EX stage; flags = {eq, less, ge, less_u, ge_u}
  task automatic applyStimulus(input logic v, input logic br, input logic [2:0] f3,
                               input logic [4:0] flags, input logic [31:0] pc,
                               input logic pred, input logic fl);
    bus.ex_valid      = v;
    bus.ex_branch     = br;
    bus.ex_funct3     = f3;
    bus.ex_eq         = flags[4];
    bus.ex_less       = flags[3];
    bus.ex_ge         = flags[2];
    bus.ex_less_u     = flags[1];
    bus.ex_ge_u       = flags[0];
    bus.ex_pc         = pc;
    bus.ex_pred_taken = pred;
    bus.flush         = fl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkStats(input string tag, input logic [31:0] br, input logic [31:0] ms);
`ifdef BRANCH_STATS_EN
    checkOutput({tag, "_br"}, bus.br_count, br);
    checkOutput({tag, "_miss"}, bus.miss_count, ms);
`endif
  endtask

  logic [7:0] exp_dec;

  initial begin
    vectors = 0;
    errors  = 0;
    exp_dec = 8'b1001_0010;

    // Reset state
    rst = 1'b1;
    bus.fetch_pc = 32'h0;
    applyStimulus(1'b0, 1'b0, 3'b000, 5'b00000, 32'h0, 1'b0, 1'b0);
    stepClock();
    stepClock();
    rst = 1'b0;
    checkOutput("rst_mispredict", bus.mispredict, 1'b0);
    checkOutput("rst_mis_taken", bus.mispredict_taken, 1'b0);
    checkStats("rst", 0, 0);
    for (int i = 0; i < 64; i++) begin
      bus.fetch_pc = i << 2;
      #1;
      checkOutput($sformatf("rst_pred_%0d", i), bus.pred_taken, 1'b0);
    end
    stepClock();

    // Training and saturation at 0x100 (index 0)
    bus.fetch_pc = 32'h100;
    applyStimulus(1'b1, 1'b1, 3'b000, 5'b10000, 32'h100, 1'b0, 1'b0);
    checkOutput("tr1_taken", bus.taken, 1'b1);
    checkOutput("tr1_pred_pre", bus.pred_taken, 1'b0);
    stepClock();
    checkOutput("tr1_mispredict", bus.mispredict, 1'b1);
    checkOutput("tr1_mis_taken", bus.mispredict_taken, 1'b1);
    checkOutput("tr1_pred", bus.pred_taken, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'b000, 5'b10000, 32'h100, 1'b1, 1'b0);
    stepClock();
    checkOutput("tr2_mispredict", bus.mispredict, 1'b0);
    checkOutput("tr2_mis_taken", bus.mispredict_taken, 1'b0);
    checkOutput("tr2_pred", bus.pred_taken, 1'b1);
    stepClock();
    checkOutput("tr3_mispredict", bus.mispredict, 1'b0);
    checkOutput("tr3_pred", bus.pred_taken, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'b000, 5'b00000, 32'h100, 1'b1, 1'b0);
    checkOutput("tr4_taken", bus.taken, 1'b0);
    stepClock();
    checkOutput("tr4_mispredict", bus.mispredict, 1'b1);
    checkOutput("tr4_mis_taken", bus.mispredict_taken, 1'b0);
    checkOutput("tr4_pred_sat", bus.pred_taken, 1'b1);
    applyStimulus(1'b0, 1'b0, 3'b000, 5'b00000, 32'h100, 1'b0, 1'b0);
    stepClock();
    checkOutput("idle_mispredict", bus.mispredict, 1'b0);
    checkStats("train", 4, 2);

    // Decode table with flush held so the table is not trained
    for (int f = 0; f < 8; f++) begin
      applyStimulus(1'b1, 1'b1, 3'(f), 5'b01001, 32'h100, 1'b0, 1'b1);
      checkOutput($sformatf("dec_f3_%0d", f), bus.taken, 32'(exp_dec[f]));
    end
    stepClock();
    checkOutput("dec_flush_mispredict", bus.mispredict, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b001, 5'b00000, 32'h100, 1'b0, 1'b0);
    checkOutput("dec_nonbranch", bus.taken, 1'b0);

    // Illegal funct3 leaves table and mispredict alone
    applyStimulus(1'b1, 1'b1, 3'b010, 5'b11111, 32'h100, 1'b1, 1'b0);
    checkOutput("ill010_taken", bus.taken, 1'b0);
    stepClock();
    checkOutput("ill010_mispredict", bus.mispredict, 1'b0);
    checkOutput("ill010_pred", bus.pred_taken, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'b011, 5'b11111, 32'h100, 1'b1, 1'b0);
    stepClock();
    checkOutput("ill011_mispredict", bus.mispredict, 1'b0);
    checkOutput("ill011_pred", bus.pred_taken, 1'b1);

    // Flushed and invalid BNE at 0x80
    bus.fetch_pc = 32'h80;
    applyStimulus(1'b1, 1'b1, 3'b001, 5'b00000, 32'h80, 1'b0, 1'b1);
    checkOutput("flush_taken", bus.taken, 1'b1);
    stepClock();
    checkOutput("flush_mispredict", bus.mispredict, 1'b0);
    checkOutput("flush_pred", bus.pred_taken, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b001, 5'b00000, 32'h80, 1'b0, 1'b0);
    checkOutput("inval_taken", bus.taken, 1'b0);
    stepClock();
    checkOutput("inval_mispredict", bus.mispredict, 1'b0);
    checkOutput("inval_pred", bus.pred_taken, 1'b0);
    checkStats("flush", 4, 2);

    // Read/write collision at 0x40 (index 16)
    bus.fetch_pc = 32'h40;
    applyStimulus(1'b1, 1'b1, 3'b000, 5'b10000, 32'h40, 1'b0, 1'b0);
    checkOutput("coll_pred_same", bus.pred_taken, 1'b0);
    stepClock();
    checkOutput("coll_pred_next", bus.pred_taken, 1'b1);
    checkOutput("coll_mispredict", bus.mispredict, 1'b1);
    checkOutput("coll_mis_taken", bus.mispredict_taken, 1'b1);

    // 0x140 aliases onto index 16
    applyStimulus(1'b1, 1'b1, 3'b000, 5'b10000, 32'h140, 1'b1, 1'b0);
    stepClock();
    checkOutput("alias1_mispredict", bus.mispredict, 1'b0);
    checkOutput("alias1_pred", bus.pred_taken, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'b000, 5'b00000, 32'h140, 1'b1, 1'b0);
    stepClock();
    checkOutput("alias2_mispredict", bus.mispredict, 1'b1);
    checkOutput("alias2_mis_taken", bus.mispredict_taken, 1'b0);
    checkOutput("alias2_pred", bus.pred_taken, 1'b1);
    stepClock();
    checkOutput("alias3_mispredict", bus.mispredict, 1'b1);
    checkOutput("alias3_pred", bus.pred_taken, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b000, 5'b00000, 32'h0, 1'b0, 1'b0);
    stepClock();
    checkStats("alias", 8, 5);

    // Reset mid-run beats a concurrent update and discards training
    bus.fetch_pc = 32'h100;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 3'b000, 5'b10000, 32'h100, 1'b0, 1'b0);
    stepClock();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 5'b00000, 32'h0, 1'b0, 1'b0);
    checkOutput("rst2_pred", bus.pred_taken, 1'b0);
    checkOutput("rst2_mispredict", bus.mispredict, 1'b0);
    checkStats("rst2", 0, 0);

    // Five resolves at 0x200, two mispredicted
    bus.fetch_pc = 32'h200;
    applyStimulus(1'b1, 1'b1, 3'b000, 5'b10000, 32'h200, 1'b0, 1'b0);
    stepClock();
    checkStats("st1", 1, 0);
    applyStimulus(1'b1, 1'b1, 3'b000, 5'b10000, 32'h200, 1'b1, 1'b0);
    stepClock();
    stepClock();
    applyStimulus(1'b1, 1'b1, 3'b000, 5'b00000, 32'h200, 1'b1, 1'b0);
    stepClock();
    checkOutput("st4_mispredict", bus.mispredict, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'b000, 5'b00000, 32'h200, 1'b0, 1'b0);
    stepClock();
    checkOutput("st5_mispredict", bus.mispredict, 1'b0);
    checkOutput("st5_pred", bus.pred_taken, 1'b0);
    checkStats("st5", 5, 2);
    applyStimulus(1'b0, 1'b0, 3'b000, 5'b00000, 32'h0, 1'b0, 1'b0);
    stepClock();
    checkStats("st_idle", 5, 2);
    rst = 1'b1;
    stepClock();
    rst = 1'b0;
    checkStats("st_rst", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
